// File: rtl/bram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO on an inferred simple-dual-port block RAM.
// The RAM read register is the output register, so capacity is 2**AddrBits + 1 words.
module bram_sync_fifo #(
  parameter int DataWidth        = 8,
  parameter int AddrBits         = 9,
  parameter int AlmostFullLevel  = 496,
  parameter int AlmostEmptyLevel = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [DataWidth-1:0] InData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DataWidth-1:0] OutData,
  output logic [AddrBits:0]    Level,
  output logic                 AlmostFull,
  output logic                 AlmostEmpty
);

  localparam int Depth = 2 ** AddrBits;
  localparam logic [AddrBits:0] DepthCount = (AddrBits + 1)'(Depth);
  localparam logic [AddrBits:0] AfLevel    = (AddrBits + 1)'(AlmostFullLevel);
  localparam logic [AddrBits:0] AeLevel    = (AddrBits + 1)'(AlmostEmptyLevel);

  typedef struct packed {
    logic [AddrBits-1:0] wr_ptr;
    logic [AddrBits-1:0] rd_ptr;
    logic [AddrBits:0]   ram_count;
    logic                out_valid;
    logic [AddrBits:0]   level;
    logic                almost_full;
    logic                almost_empty;
  } state_t;

  // Reset and Flush share this value; an empty FIFO is always almost-empty.
  localparam state_t StateIdle = '{
    wr_ptr:       '0,
    rd_ptr:       '0,
    ram_count:    '0,
    out_valid:    1'b0,
    level:        '0,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  (* ram_style = "block" *) logic [DataWidth-1:0] mem_q [Depth];

  state_t                 state_q, state_d;
  logic [DataWidth-1:0]   out_data_q;
  logic                   wr_en, rd_en;

  // InReady depends only on registered state and the control inputs, so a
  // consumer stall can never ripple combinationally back to the producer.
  always_comb begin
    InReady = !Reset && !Flush && (state_q.ram_count < DepthCount);
    wr_en   = InValid && InReady;
    rd_en   = !Flush && (state_q.ram_count != '0) && (!state_q.out_valid || OutReady);
  end

  // NOTE: every field gets its default first, so no path through this block
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (wr_en) state_d.wr_ptr = state_q.wr_ptr + 1'b1;
    if (rd_en) state_d.rd_ptr = state_q.rd_ptr + 1'b1;
    state_d.ram_count = state_q.ram_count + (AddrBits + 1)'(wr_en)
                                          - (AddrBits + 1)'(rd_en);
    if (rd_en)         state_d.out_valid = 1'b1;
    else if (OutReady) state_d.out_valid = 1'b0;
    state_d.level        = state_d.ram_count + (AddrBits + 1)'(state_d.out_valid);
    state_d.almost_full  = (state_d.level >= AfLevel);
    state_d.almost_empty = (state_d.level <= AeLevel);
    if (Flush) state_d = StateIdle;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= StateIdle;
    else       state_q <= state_d;
  end

  // NOTE: the storage array is deliberately not reset; a reset port on the
  // array would prevent block-RAM inference. Stale contents are unreachable
  // because occupancy, not memory contents, gates every read.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[state_q.wr_ptr] <= InData;
  end

  // Read register kept in its own process with a plain indexed read so the
  // tools map it onto the BRAM output register (sync reset is supported there).
  always_ff @(posedge Clk) begin
    if (Reset || Flush) out_data_q <= '0;
    else if (rd_en)     out_data_q <= mem_q[state_q.rd_ptr];
  end

  assign OutData     = out_data_q;
  assign OutValid    = state_q.out_valid;
  assign Level       = state_q.level;
  assign AlmostFull  = state_q.almost_full;
  assign AlmostEmpty = state_q.almost_empty;

  // Occupancy excludes the in-flight write, so these hold by construction.
  a_no_rw_collision: assert property (@(posedge Clk) disable iff (Reset)
    !(wr_en && rd_en && (state_q.wr_ptr == state_q.rd_ptr)));
  a_count_bound: assert property (@(posedge Clk) disable iff (Reset)
    state_q.ram_count <= DepthCount);

endmodule
